instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle control sequencer for the 9-bit processor. Sits between the
//  instruction decoder and the fetch unit, register file, data memory and LUT.
//  Runs the fetch/execute/memory/LUT-second-phase cycle and owns the bench
//  Start/Done handshake. Gates PC advance and write-back. Keeps cycle and
//  retired-instruction counters.
// PARAMETERS
//  CNT_W        16  width of CycleCnt and InstrCnt (saturating)
//  MEM_TIMEOUT  8   max cycles in MEM waiting for MemReady before Fault
// PORTS
//  Clk          in   1      single clock, all state on posedge
//  Reset        in   1      synchronous, active-high
//  Start        in   1      bench: high = hold/init PC, falling = run
//  DecHalt      in   1      decoded all-ones instruction (program done)
//  DecRegWr     in   1      decoder register-write enable
//  DecMemRd     in   1      lw/lwl class
//  DecMemWr     in   1      sw/swl class
//  DecBranch    in   1      conditional branch (boo/bol)
//  DecJump      in   1      unconditional redirect (sne/seq set-and-jump)
//  DecLUT2x     in   1      two-phase LUT instruction
//  BranchTaken  in   1      ALU condition flag, valid in EXEC
//  MemReady     in   1      data memory completes the access this cycle
//  PcRst        out  1      force PC to start address
//  PcEn         out  1      advance PC (next or target) this cycle
//  PcLoad       out  1      with PcEn: take target instead of PC+1
//  IrLoad       out  1      latch instruction ROM output
//  WbEn         out  1      gated register-file write
//  MemReq       out  1      data memory request, held until MemReady
//  LutPhase     out  1      1 = second LUT cycle
//  Busy         out  1      program running (FETCH/EXEC/MEM/LUT2)
//  Done         out  1      program halted, held until next Start
//  Fault        out  1      sticky: memory timeout occurred this run
//  CycleCnt     out  CNT_W  cycles spent running this program
//  InstrCnt     out  CNT_W  instructions retired this program
// BEHAVIOUR
//  Reset (any state, any cycle): state=IDLE; every output 0; counters 0,
//   Fault 0. An access in flight is abandoned: MemReq drops the next cycle.
//  States: IDLE, INIT, FETCH, EXEC, MEM, LUT2, HALT. All outputs are a
//   Moore/Mealy decode of the registered state. No output is registered
//   except the counters and Fault.
//  IDLE: outputs 0. Start=1 -> INIT.
//  INIT: PcRst=1. Counters and Fault clear. Stay while Start=1.
//   Start=0 -> FETCH.
//  FETCH: IrLoad=1, Busy=1 -> EXEC (1 cycle).
//  EXEC (priority order):
//   DecHalt -> HALT. Nothing retired, no PcEn, no WbEn.
//   DecMemRd|DecMemWr -> MEM. No PcEn this cycle.
//   DecLUT2x -> LUT2. LutPhase=0.
//   else: PcEn=1; PcLoad=DecJump|(DecBranch&BranchTaken);
//    WbEn=DecRegWr; retire -> FETCH.
//  MEM: MemReq=1; wait counter increments each cycle.
//   MemReady=1 -> PcEn=1, WbEn=DecMemRd&DecRegWr, retire -> FETCH.
//   Wait counter reaches MEM_TIMEOUT without MemReady -> Fault=1 -> HALT.
//    No retire, no write-back.
//   MemReady in the same cycle as timeout: MemReady wins.
//  LUT2: LutPhase=1, PcEn=1, WbEn=DecRegWr, retire -> FETCH.
//  HALT: Done=1, Busy=0, all other strobes 0. Start=1 -> INIT.
//  Start while Busy: ignored.
//  Decoder inputs are sampled only in EXEC/MEM/LUT2. The IR holds stable
//   from IrLoad until the next IrLoad.
//  CycleCnt: +1 every cycle with Busy=1. InstrCnt: +1 on each retire.
//   Both saturate at all-ones (no wrap). Both hold value in HALT.
//  Latency per instruction: ALU/branch 2 cycles, LUT 3 cycles,
//   memory 2 + wait cycles (wait >= 1).
// STRUCTURE
//  Definitions package: seq_state_t enum (7 states, 3-bit),
//   SEQ_START_ADDR constant.
//  One sub-module: sat_counter #(W). Sync-reset, clear, inc, saturate.
//   Instantiated twice (CycleCnt, InstrCnt).
//  MEM wait counter and FSM are kept local.
// TESTING
//  Start 1 for 3 cycles then 0; ALU op then halt -> PcRst high 3 cycles;
//   IrLoad, PcEn; Done=1; InstrCnt=1; CycleCnt=4.
//  Branch in EXEC with BranchTaken=1 -> PcEn=1 and PcLoad=1 same cycle.
//   With BranchTaken=0 -> PcLoad=0.
//  lw with MemReady after 3 MEM cycles -> MemReq high exactly 3 cycles;
//   WbEn=1 on 3rd; Fault=0.
//  MemReady never (MEM_TIMEOUT=8) -> Fault=1 after 8 MEM cycles; HALT;
//   Done=1; no WbEn.
//  Reset asserted mid-MEM -> next cycle all outputs 0, state IDLE,
//   counters 0. Start pulse mid-run ignored.
//  CNT_W=4, 20-instruction loop -> InstrCnt/CycleCnt stick at 15.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// Module : instr_sequencer_pkg
// Brief  : Shared state encoding and start address for the control sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_LUT2  = 3'd5,
    S_HALT  = 3'd6
  } seq_state_t;

  localparam logic [7:0] SEQ_START_ADDR = 8'd0;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter with sync reset, clear and saturation at all-ones.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module : instr_sequencer
// Brief  : Fetch/execute/memory/LUT control sequencer with Start/Done handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             DecHalt,
  input  logic             DecRegWr,
  input  logic             DecMemRd,
  input  logic             DecMemWr,
  input  logic             DecBranch,
  input  logic             DecJump,
  input  logic             DecLUT2x,
  input  logic             BranchTaken,
  input  logic             MemReady,
  output logic             PcRst,
  output logic             PcEn,
  output logic             PcLoad,
  output logic             IrLoad,
  output logic             WbEn,
  output logic             MemReq,
  output logic             LutPhase,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstrCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic              retire;
  logic              cnt_clr;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    PcRst    = 1'b0;
    PcEn     = 1'b0;
    PcLoad   = 1'b0;
    IrLoad   = 1'b0;
    WbEn     = 1'b0;
    MemReq   = 1'b0;
    LutPhase = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_INIT;
      end
      S_INIT: begin
        PcRst   = 1'b1;
        fault_d = 1'b0;
        if (!Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        IrLoad  = 1'b1;
        Busy    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        Busy   = 1'b1;
        wait_d = '0;
        if (DecHalt) begin
          state_d = S_HALT;
        end else if (DecMemRd || DecMemWr) begin
          state_d = S_MEM;
        end else if (DecLUT2x) begin
          state_d = S_LUT2;
        end else begin
          PcEn    = 1'b1;
          PcLoad  = DecJump || (DecBranch && BranchTaken);
          WbEn    = DecRegWr;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        Busy   = 1'b1;
        MemReq = 1'b1;
        wait_d = wait_q + 1'b1;
        // A completion on the final allowed cycle still counts as success.
        if (MemReady) begin
          PcEn    = 1'b1;
          WbEn    = DecMemRd && DecRegWr;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_LUT2: begin
        Busy     = 1'b1;
        LutPhase = 1'b1;
        PcEn     = 1'b1;
        WbEn     = DecRegWr;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        Done = 1'b1;
        if (Start) state_d = S_INIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign Fault   = fault_q;
  assign cnt_clr = (state_q == S_INIT);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_clr (cnt_clr),
    .i_inc (Busy),
    .o_cnt (CycleCnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_clr (cnt_clr),
    .i_inc (retire),
    .o_cnt (InstrCnt)
  );

endmodule

`default_nettype wire
